// File: rtl/div_radix2_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: width, FSM state codes,
// and the HI/LO write-select code the decoder uses to route a divide.
package div_radix2_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // hi_mdr/lo_mdr select value that steers a divide result into HI/LO.
    localparam logic [1:0] MDR_SEL_DIV = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_ZERO = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_radix2_unit_sign_fix.sv
// Conditional two's-complement negation of two values; used for the operand
// absolute values on entry and for the quotient/remainder sign fix on exit.
module div_radix2_unit_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg_a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_b,
    output logic [WIDTH-1:0] a_fixed,
    output logic [WIDTH-1:0] b_fixed
);

    assign a_fixed = neg_a ? -a : a;
    assign b_fixed = neg_b ? -b : b;

endmodule

// File: rtl/div_radix2_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Define DIV_ZERO_FASTPATH_EN to finish divide-by-zero in one ZERO cycle instead of WIDTH.
module div_radix2_unit
    import div_radix2_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_req
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     counter_q;
    logic [WIDTH-1:0]     rem_q, quo_q, divisor_q;
    logic                 signed_q, sign_a_q, sign_b_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_ext, diff;
    logic                 fits;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;
    logic                 accept, div_by_zero;

    assign accept      = (state_q == DIV_IDLE) && start && !annul;
    assign div_by_zero = (opdata2 == '0);

    div_radix2_unit_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
        .a       (opdata1),
        .neg_a   (signed_div & opdata1[WIDTH-1]),
        .b       (opdata2),
        .neg_b   (signed_div & opdata2[WIDTH-1]),
        .a_fixed (abs_a),
        .b_fixed (abs_b)
    );

    // One restoring step: shift {rem, quo} left, then trial-subtract the divisor.
    // The extra top bit keeps the compare exact for divisors at or above 2^(WIDTH-1).
    assign rem_ext  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = rem_ext - {1'b0, divisor_q};
    assign fits     = !diff[WIDTH];
    assign rem_step = fits ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], fits};

    div_radix2_unit_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
        .a       (quo_step),
        .neg_a   (signed_q & (sign_a_q ^ sign_b_q)),
        .b       (rem_step),
        .neg_b   (signed_q & sign_a_q),
        .a_fixed (quo_fixed),
        .b_fixed (rem_fixed)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d; a missing branch would infer a latch.
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (accept) state_d = div_by_zero ? DIV_ZERO : DIV_BUSY;
            end
            DIV_BUSY: begin
                if (annul)                       state_d = DIV_IDLE;
                else if (counter_q == CNT_LAST)  state_d = DIV_DONE;
            end
            DIV_ZERO: begin
`ifdef DIV_ZERO_FASTPATH_EN
                state_d = annul ? DIV_IDLE : DIV_DONE;
`else
                if (annul)                       state_d = DIV_IDLE;
                else if (counter_q == CNT_LAST)  state_d = DIV_DONE;
`endif
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                counter_q <= '0;
                rem_q     <= '0;
                // Divide-by-zero keeps the raw dividend; it becomes HI unchanged.
                quo_q     <= div_by_zero ? opdata1 : abs_a;
                divisor_q <= abs_b;
                signed_q  <= signed_div;
                sign_a_q  <= opdata1[WIDTH-1];
                sign_b_q  <= opdata2[WIDTH-1];
            end
            if (state_q == DIV_BUSY) begin
                counter_q <= counter_q + CNT_W'(1);
                rem_q     <= rem_step;
                quo_q     <= quo_step;
                if (state_d == DIV_DONE) result_q <= {rem_fixed, quo_fixed};
            end
            if (state_q == DIV_ZERO) begin
                counter_q <= counter_q + CNT_W'(1);
                if (state_d == DIV_DONE) result_q <= {quo_q, {WIDTH{1'b1}}};
            end
        end
    end

    assign result    = result_q;
    assign ready     = (state_q == DIV_DONE);
    assign stall_req = start & ~ready;

endmodule

// File: tb/tb_div_radix2_unit.sv
// Directed self-checking bench for div_radix2_unit: latency, signed/unsigned
// results, divide-by-zero, annul, async reset mid-operation and back-to-back issue.
module tb_div_radix2_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opdata1, opdata2;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall_req;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_radix2_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide in the current cycle (cycle 0), hold start until ready,
    // then check latency, stall, result and the single-cycle ready pulse.
    task automatic run_div(input string tag, input logic sd, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int cyc = 0;
        int stall_bad = 0;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1;
        while (!ready && cyc < 60) begin
            if (stall_req !== 1'b1) stall_bad++;
            tick();
            cyc++;
        end
        check({tag, " ready_cycle"}, 64'(cyc), 64'(exp_lat));
        check({tag, " stall_while_busy"}, 64'(stall_bad), 64'd0);
        check({tag, " stall_at_ready"}, 64'(stall_req), 64'd0);
        check({tag, " lo"}, 64'(result[W-1:0]), 64'(exp_lo));
        check({tag, " hi"}, 64'(result[2*W-1:W]), 64'(exp_hi));
        start = 1'b0;
        tick();
        check({tag, " ready_one_cycle"}, 64'(ready), 64'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        #2;
        check("reset result", result, 64'd0);
        check("reset ready", 64'(ready), 64'd0);
        check("reset stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // T1: DIVU 100/7
        run_div("T1 divu 100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("divu big/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF);
        run_div("divu 5/big", 1'b0, 32'd5, 32'hF000_0000, 33, 32'd0, 32'd5);

        // T2: signed combinations
        run_div("T2 div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("T2 div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd3, 32'hFFFF_FFFF);
        run_div("divu -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1);

        // T3: overflow case, no trap
        run_div("T3 div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // T4: divide by zero, raw dividend in HI
        run_div("T4 divu 0x1234/0", 1'b0, 32'h1234, 32'd0, ZERO_LAT, 32'hFFFF_FFFF, 32'h1234);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, ZERO_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // T5: annul in cycle 10 of BUSY; prior result (from -5/0) must survive
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        check("T5 no ready after annul", 64'(ready), 64'd0);
        check("T5 result kept", result, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        annul = 1'b0;
        tick();
        run_div("T5 restart 1000/3", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1);
        annul = 1'b1;
        start = 1'b1;
        opdata2 = 32'd7;
        tick();
        annul = 1'b0;
        start = 1'b0;
        tick();
        check("annul blocks accept", 64'(ready), 64'd0);
        repeat (35) begin
            if (ready) failures++;
            tick();
        end
        check("annul no later ready", result, {32'd1, 32'd333});

        // T6: async reset in cycle 20, then normal issue and back-to-back
        opdata1 = 32'd50;
        opdata2 = 32'd4;
        start   = 1'b1;
        repeat (20) tick();
        resetn = 1'b0;
        #1;
        check("T6 reset result", result, 64'd0);
        check("T6 reset ready", 64'(ready), 64'd0);
        start = 1'b0;
        #1;
        check("T6 reset stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        run_div("T6 after reset 50/4", 1'b0, 32'd50, 32'd4, 33, 32'd12, 32'd2);
        run_div("T6 back-to-back 9/3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
